sh_mem_responder: RTL and testbench
===================================

Name: sh_mem_responder

Overview:
On-chip data-memory responder for the SH2 core's data bus, i.e. the slave end of the CPU memory-access stage.
Accepts byte/word/long read and write requests (SZ encoded as MemSize_t), applies configurable wait states, and returns an acknowledge.
Returns read data as the full big-endian aligned word; the CPU extracts the addressed lane.
Sits between the core's memory-access port and an inferred byte-enabled SRAM.

Parameters:
ADDR_W, 12, word-address width; memory depth = 2**ADDR_W 32-bit words (16 KB default)
WAIT_RD, 1, wait states inserted before ACK on reads (0..15)
WAIT_WR, 0, wait states inserted before ACK on writes (0..15)

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
CE  in  1  clock enable; all state advances only when CE=1
REQ  in  1  access request; held by CPU until ACK
WE  in  1  1=write, 0=read; qualified by REQ
SZ  in  2  access size: 0=BYTE, 1=WORD, 2=LONG, 3=reserved
A  in  ADDR_W+2  byte address
DI  in  32  write data, right-justified (byte in DI[7:0], word in DI[15:0])
DO  out  32  read data, full aligned word, big-endian lanes (A[1:0]=0 -> DO[31:24])
ACK  out  1  one-CE-cycle completion pulse
BUSY  out  1  high from request capture until ACK
ERR  out  1  one-CE-cycle bus-error pulse (optional feature only)

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: DO=0, ACK=0, BUSY=0, ERR=0, FSM=IDLE, wait counter=0. SRAM contents are not reset.
- FSM states:
  - IDLE: on CE && REQ, capture A, WE, SZ, DI. Load counter with WAIT_RD or WAIT_WR. Set BUSY=1. Go to WAIT if the wait count is >0, else DONE.
  - WAIT: on CE, decrement the counter. When the counter reaches 1, go to DONE.
  - DONE: on CE, perform the access, pulse ACK=1, clear BUSY, go to IDLE.
- Latency: ACK rises (wait+1) CE cycles after the capture edge. Zero-wait read: capture at edge n, ACK and DO valid after edge n+1.
- Writes commit only at the edge that raises ACK. A write aborted by reset before that edge is never committed.
- Byte enables from captured SZ and A[1:0]:
  - BYTE: 1000 >> A[1:0].
  - WORD: 1100 >> {A[1],0}.
  - LONG: 1111.
- Write lane placement: DI is replicated onto the selected lanes. BYTE writes DI[7:0] to each lane; WORD writes DI[15:0] to each half.
- Reads: DO is loaded with the whole word at A[ADDR_W+1:2] and held until the next read's ACK. Writes leave DO unchanged.
- Back-to-back: a REQ present in the cycle after ACK is captured normally. ACK never occurs on consecutive CE cycles.
- REQ deasserted mid-access is ignored; the captured access completes.
- CE=0: outputs, state and counter are frozen; an ACK pulse is extended until the next CE cycle.
- Misalignment without the optional feature: A[0] is ignored for WORD, A[1:0] ignored for LONG. SZ=3 is treated as LONG.

Optional Feature:
SH_MEM_RESP_BUSERR_EN:
- Defined: a misaligned WORD (A[0]=1), misaligned LONG (A[1:0]!=0), or SZ=3 goes from capture straight to DONE, skipping wait states.
- In that DONE cycle, ERR=1 and ACK=1 together; no write is performed and DO is unchanged.
- Undefined: the ERR port is tied to 0 and the alignment rules in Behaviour apply.

Decomposition:
- Add to the shared SH2 package:
  - RespState_t enum {IDLE, WAIT, DONE}.
  - function ByteEnable(size[1:0], a[1:0]) returning 4 bits.
  - function LaneReplicate(size, di) returning 32 bits.
- MemSize_t encoding is reused for SZ.
- One sub-module: sh_mem_sram, a single-port RAM with 4 byte write-enables and a registered read, parameterised by ADDR_W.

Test Plan:
- Reset with RST_N=0 mid-WAIT of a write 0x11223344 to A=0x10 -> outputs return to 0 asynchronously; a later read of 0x10 does not return 0x11223344.
- WAIT_WR=0, write LONG 0xDEADBEEF to A=0x20, then WAIT_RD=1 read A=0x20 -> write ACK 1 cycle after capture; read ACK 2 cycles after capture with DO=0xDEADBEEF.
- BYTE write DI=0x000000A5 to A=0x21 over 0xDEADBEEF, then LONG read A=0x20 -> DO=0xDEA5BEEF.
- WORD write DI=0x00001234 to A=0x22, then read A=0x20 -> DO=0xDEA51234; BUSY high exactly from capture to ACK.
- Back-to-back reads of A=0x20 and A=0x24 with REQ held continuously -> two ACK pulses separated by exactly one non-ACK CE cycle (WAIT_RD=0); CE toggled 1/0 stretches every timing by idle cycles only.
- With SH_MEM_RESP_BUSERR_EN: LONG write to A=0x22 -> ERR=ACK=1 one cycle after capture; memory unchanged. Without the macro, the same write stores at word 0x20 and ERR stays 0.

Source files
------------

// File: rtl/sh_mem_responder_pkg.sv
// Shared SH2 data-bus types and lane helpers for the on-chip memory responder.
// Misalignment check is used only when SH_MEM_RESP_BUSERR_EN is defined.
package sh_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_WORD = 2'd1,
        SZ_LONG = 2'd2,
        SZ_RSVD = 2'd3
    } MemSize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } RespState_t;

    // Big-endian lanes: be[3] is DO[31:24], the byte at A[1:0]=0.
    function automatic logic [3:0] ByteEnable(input logic [1:0] size,
                                              input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b1000 >> a;
            SZ_WORD: be = 4'b1100 >> {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] LaneReplicate(input logic [1:0] size,
                                                  input logic [31:0] di);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{di[7:0]}};
            SZ_WORD: d = {2{di[15:0]}};
            default: d = di;
        endcase
        return d;
    endfunction

    function automatic logic Misaligned(input logic [1:0] size,
                                        input logic [1:0] a);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_WORD: bad = a[0];
            SZ_LONG: bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/sh_mem_sram.sv
// Single-port 32-bit RAM with four byte write-enables and a registered read.
// The read register resets to zero; the array itself is never reset.
module sh_mem_sram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is held until the next read access.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sh_mem_responder.sv
// SH2 data-bus memory responder: wait states, byte lanes, one-cycle ACK.
// Define SH_MEM_RESP_BUSERR_EN to flag misaligned/reserved accesses on ERR.
module sh_mem_responder #(
    parameter int ADDR_W  = 12,
    parameter int WAIT_RD = 1,
    parameter int WAIT_WR = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SZ,
    input  logic [ADDR_W+1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              ACK,
    output logic              BUSY,
    output logic              ERR
);
    import sh_mem_responder_pkg::*;

    RespState_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic              bad_q, bad_d;
    MemSize_t          sz_q, sz_d;
    logic [ADDR_W+1:0] a_q, a_d;
    logic [31:0]       di_q, di_d;
    logic [3:0]        wait_ld;
    logic              bad_c;
    logic              mem_en;

    assign wait_ld = WE ? 4'(WAIT_WR) : 4'(WAIT_RD);

`ifdef SH_MEM_RESP_BUSERR_EN
    assign bad_c = Misaligned(SZ, A[1:0]);
`else
    assign bad_c = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        we_d    = we_q;
        bad_d   = bad_q;
        sz_d    = sz_q;
        a_d     = a_q;
        di_d    = di_q;
        mem_en  = 1'b0;
        if (CE) begin
            ack_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (REQ) begin
                        a_d    = A;
                        we_d   = WE;
                        sz_d   = MemSize_t'(SZ);
                        di_d   = DI;
                        bad_d  = bad_c;
                        busy_d = 1'b1;
                        cnt_d  = wait_ld;
                        // Faulting accesses skip the wait states entirely.
                        if (wait_ld != 4'd0 && !bad_c) begin
                            state_d = WAIT;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    mem_en  = !bad_q;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            sz_q    <= SZ_BYTE;
            a_q     <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            sz_q    <= sz_d;
            a_q     <= a_d;
            di_q    <= di_d;
        end
    end

`ifdef SH_MEM_RESP_BUSERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (CE) begin
            err_d = (state_q == DONE) && bad_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    sh_mem_sram #(
        .ADDR_W(ADDR_W)
    ) u_sram (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (mem_en),
        .we    (we_q),
        .be    (ByteEnable(sz_q, a_q[1:0])),
        .addr  (a_q[ADDR_W+1:2]),
        .wdata (LaneReplicate(sz_q, di_q)),
        .rdata (DO)
    );

    assign ACK  = ack_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_sh_mem_responder.sv
// Directed bench for sh_mem_responder: two instances with different wait states.
// Expectations for the misaligned LONG write follow SH_MEM_RESP_BUSERR_EN.
module tb_sh_mem_responder;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE    = 1'b1;
    logic        REQ   = 1'b0;
    logic        WE    = 1'b0;
    logic        sel   = 1'b0;
    logic [1:0]  SZ    = 2'd2;
    logic [13:0] A     = '0;
    logic [31:0] DI    = '0;

    logic [31:0] do0, do1;
    logic        ack0, ack1, busy0, busy1, err0, err1;

    wire        req0   = REQ & ~sel;
    wire        req1   = REQ & sel;
    wire [31:0] do_o   = sel ? do1 : do0;
    wire        ack_o  = sel ? ack1 : ack0;
    wire        busy_o = sel ? busy1 : busy0;
    wire        err_o  = sel ? err1 : err0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    sh_mem_responder #(
        .ADDR_W(12), .WAIT_RD(1), .WAIT_WR(0)
    ) u_d0 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .REQ(req0), .WE(WE),
        .SZ(SZ), .A(A), .DI(DI), .DO(do0), .ACK(ack0),
        .BUSY(busy0), .ERR(err0)
    );

    sh_mem_responder #(
        .ADDR_W(12), .WAIT_RD(0), .WAIT_WR(2)
    ) u_d1 (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .REQ(req1), .WE(WE),
        .SZ(SZ), .A(A), .DI(DI), .DO(do1), .ACK(ack1),
        .BUSY(busy1), .ERR(err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access; lat counts clock edges from capture to the ACK edge.
    task automatic access(input logic s, input logic w, input logic [1:0] z,
                          input logic [13:0] a, input logic [31:0] d,
                          input logic tog, output int lat,
                          output logic busy_ok, output logic err_ack,
                          output logic [31:0] do_ack);
        @(negedge CLK);
        sel = s; WE = w; SZ = z; A = a; DI = d; REQ = 1'b1; CE = 1'b1;
        @(posedge CLK);
        #1;
        REQ     = 1'b0;
        lat     = 0;
        busy_ok = busy_o;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if (tog) CE = ~CE;
            @(posedge CLK);
            #1;
            lat++;
            if (ack_o) break;
            if (!busy_o) busy_ok = 1'b0;
        end
        if (busy_o) busy_ok = 1'b0;
        err_ack = err_o;
        do_ack  = do_o;
        check("ack_seen", 32'(ack_o), 32'd1);
    endtask

    int          lat;
    logic        bok, e;
    logic [31:0] dq;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_do0", do0, 32'h0);
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_do1", do1, 32'h0);
        check("rst_busy1", 32'(busy1), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        access(1, 1, 2'd2, 14'h010, 32'hCAFEF00D, 0, lat, bok, e, dq);
        check("wr_lat_ws2", 32'(lat), 32'd3);

        @(negedge CLK);
        sel = 1; WE = 1; SZ = 2'd2; A = 14'h010; DI = 32'h11223344; REQ = 1;
        @(posedge CLK);
        #1;
        REQ = 0;
        @(posedge CLK);
        #1;
        check("abort_busy_pre", 32'(busy1), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("abort_busy_rst", 32'(busy1), 32'd0);
        check("abort_ack_rst", 32'(ack1), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        access(1, 0, 2'd2, 14'h010, 32'h0, 0, lat, bok, e, dq);
        check("abort_rd_lat", 32'(lat), 32'd1);
        check("abort_rd_do", dq, 32'hCAFEF00D);

        access(0, 1, 2'd2, 14'h020, 32'hDEADBEEF, 0, lat, bok, e, dq);
        check("wr_long_lat", 32'(lat), 32'd1);
        access(0, 0, 2'd2, 14'h020, 32'h0, 0, lat, bok, e, dq);
        check("rd_long_lat", 32'(lat), 32'd2);
        check("rd_long_do", dq, 32'hDEADBEEF);

        access(0, 1, 2'd0, 14'h021, 32'h000000A5, 0, lat, bok, e, dq);
        check("wr_byte_do_hold", dq, 32'hDEADBEEF);
        check("wr_byte_err", 32'(e), 32'd0);
        access(0, 0, 2'd2, 14'h020, 32'h0, 0, lat, bok, e, dq);
        check("rd_byte_do", dq, 32'hDEA5BEEF);

        access(0, 1, 2'd1, 14'h022, 32'h00001234, 0, lat, bok, e, dq);
        check("wr_word_busy", 32'(bok), 32'd1);
        access(0, 0, 2'd2, 14'h020, 32'h0, 0, lat, bok, e, dq);
        check("rd_word_do", dq, 32'hDEA51234);
        check("rd_word_busy", 32'(bok), 32'd1);

        access(1, 1, 2'd2, 14'h020, 32'h13572468, 0, lat, bok, e, dq);
        access(1, 1, 2'd2, 14'h024, 32'h0BADF00D, 0, lat, bok, e, dq);
        check("wr_ws2_busy", 32'(bok), 32'd1);

        @(negedge CLK);
        sel = 1; WE = 0; SZ = 2'd2; A = 14'h020; REQ = 1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("b2b_ack1", 32'(ack_o), 32'd1);
        check("b2b_do1", do_o, 32'h13572468);
        @(negedge CLK);
        A = 14'h024;
        @(posedge CLK);
        #1;
        check("b2b_gap", 32'(ack_o), 32'd0);
        @(posedge CLK);
        #1;
        check("b2b_ack2", 32'(ack_o), 32'd1);
        check("b2b_do2", do_o, 32'h0BADF00D);
        @(negedge CLK);
        REQ = 0;
        @(posedge CLK);
        #1;
        check("b2b_idle_ack", 32'(ack_o), 32'd0);
        check("b2b_idle_busy", 32'(busy_o), 32'd0);

        access(0, 0, 2'd2, 14'h020, 32'h0, 1, lat, bok, e, dq);
        check("ce_lat", 32'(lat), 32'd4);
        check("ce_do", dq, 32'hDEA51234);
        @(negedge CLK);
        CE = 1'b0;
        @(posedge CLK);
        #1;
        check("ce_ack_hold", 32'(ack_o), 32'd1);
        @(negedge CLK);
        CE = 1'b1;
        @(posedge CLK);
        #1;
        check("ce_ack_drop", 32'(ack_o), 32'd0);

        access(1, 1, 2'd2, 14'h022, 32'h55667788, 0, lat, bok, e, dq);
`ifdef SH_MEM_RESP_BUSERR_EN
        check("mis_lat", 32'(lat), 32'd1);
        check("mis_err", 32'(e), 32'd1);
`else
        check("mis_lat", 32'(lat), 32'd3);
        check("mis_err", 32'(e), 32'd0);
`endif
        access(1, 0, 2'd2, 14'h020, 32'h0, 0, lat, bok, e, dq);
`ifdef SH_MEM_RESP_BUSERR_EN
        check("mis_mem", dq, 32'h13572468);
`else
        check("mis_mem", dq, 32'h55667788);
`endif
        check("mis_rd_err", 32'(e), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
